// File: rtl/seq_shift_add_mult_pkg.sv
// Shared types and sizing for the shift-and-add multiplier.
// No logic, no latency; nothing here applies backpressure.
// Holds the FSM state encoding and the default operand and counter widths.
package mult_pkg;

    localparam int MULT_WIDTH = 16;
    localparam int CNT_W      = $clog2(MULT_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_shift_add_mult_if.sv
// Operand/product handshake bundle for the shift-and-add multiplier.
// No logic and no latency of its own.
// Backpressure: valid/ready on both the operand side and the product side.
interface seq_shift_add_mult_if
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] out_prod;
    logic               busy;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_prod, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_prod, busy
    );

endinterface

// File: rtl/seq_shift_add_mult_add_step.sv
// One partial-product step: adds the multiplicand into the high half when the multiplier LSB is set.
// Latency: combinational.
// Backpressure: none; the caller decides when the result is used.
module mult_add_step
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic [WIDTH-1:0] p_hi,
    input  logic [WIDTH-1:0] a,
    input  logic             p_lsb,
    output logic [WIDTH:0]   sum
);

    always_comb begin
        sum = {1'b0, p_hi};
        if (p_lsb) begin
            sum = {1'b0, p_hi} + {1'b0, a};
        end
    end

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-and-add multiplier, one partial product per clock; SIGNED_MODE_EN selects two's complement.
// Latency: out_valid rises WIDTH edges after the accepting edge; at most one result per WIDTH+2 cycles.
// Backpressure: in_ready only in IDLE; out_valid/out_prod held stable until out_ready.
module seq_shift_add_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input logic                  clk,
    input logic                  rst_n,
    seq_shift_add_mult_if.slave  bus
);

    localparam int CW = (CNT_W > $clog2(WIDTH) + 1) ? CNT_W : $clog2(WIDTH) + 1;

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic [WIDTH:0]     step_sum;
    logic [2*WIDTH-1:0] p_step;
    logic [2*WIDTH-1:0] prod_final;
    logic [WIDTH-1:0]   mag_a, mag_b;

`ifdef SIGNED_MODE_EN
    logic sign_q, sign_d;

    // The most negative operand negates to 2^(WIDTH-1), which still fits unsigned.
    assign mag_a      = bus.in_a[WIDTH-1] ? -bus.in_a : bus.in_a;
    assign mag_b      = bus.in_b[WIDTH-1] ? -bus.in_b : bus.in_b;
    assign prod_final = sign_q ? -p_step : p_step;
`else
    assign mag_a      = bus.in_a;
    assign mag_b      = bus.in_b;
    assign prod_final = p_step;
`endif

    mult_add_step #(.WIDTH(WIDTH)) u_add_step (
        .p_hi  (p_q[2*WIDTH-1:WIDTH]),
        .a     (a_q),
        .p_lsb (p_q[0]),
        .sum   (step_sum)
    );

    // Shift right by one: the adder carry lands in the top bit, the consumed LSB drops out.
    assign p_step = {step_sum, p_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        p_d     = p_q;
        a_d     = a_q;
        prod_d  = prod_q;
`ifdef SIGNED_MODE_EN
        sign_d  = sign_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    state_d = BUSY;
                    a_d     = mag_a;
                    p_d     = {{WIDTH{1'b0}}, mag_b};
                    count_d = '0;
`ifdef SIGNED_MODE_EN
                    sign_d  = bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1];
`endif
                end
            end
            BUSY: begin
                p_d     = p_step;
                count_d = count_q + 1'b1;
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    prod_d  = prod_final;
                end
            end
            DONE: begin
                if (out_valid_q && bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            p_q         <= '0;
            a_q         <= '0;
            prod_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SIGNED_MODE_EN
            sign_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            p_q         <= p_d;
            a_q         <= a_d;
            prod_q      <= prod_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef SIGNED_MODE_EN
            sign_q      <= sign_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_prod  = prod_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Self-checking bench for seq_shift_add_mult: directed corner operands plus randomized operands and backpressure.
// Expected products come from plain integer multiplication (signed when SIGNED_MODE_EN is defined).
module tb_seq_shift_add_mult;
    import mult_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    seq_shift_add_mult_if #(.WIDTH(W)) bus ();

    seq_shift_add_mult #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mult(input logic [W-1:0] a, input logic [W-1:0] b);
        longint prod;
`ifdef SIGNED_MODE_EN
        longint sa;
        longint sb;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        prod = sa * sb;
`else
        prod = longint'(a) * longint'(b);
`endif
        return prod[2*W-1:0];
    endfunction

    task automatic check_idle(input string tag, input logic [2*W-1:0] exp_prod);
        check({tag, "_in_ready"},  bus.in_ready,  1);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_busy"},      bus.busy,      0);
        check({tag, "_out_prod"},  bus.out_prod,  exp_prod);
    endtask

    // Drives one operation end to end; hold = cycles out_ready stays low, poke = offer new operands meanwhile.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold, input bit poke);
        int               guard;
        int               lat;
        logic [2*W-1:0]   exp;
        exp = ref_mult(a, b);
        @(negedge clk);
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_wait", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_a     = W'($urandom);
        bus.in_b     = W'($urandom);
        check("busy_after_accept",     bus.busy,     1);
        check("in_ready_after_accept", bus.in_ready, 0);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, W);
        check("prod", bus.out_prod, exp);
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                bus.in_valid = 1'b1;
                bus.in_a     = W'($urandom);
                bus.in_b     = W'($urandom);
            end
            @(negedge clk);
            check("bp_valid",    bus.out_valid, 1);
            check("bp_prod",     bus.out_prod,  exp);
            check("bp_in_ready", bus.in_ready,  0);
            check("bp_busy",     bus.busy,      1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_idle("after_handoff", exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        bit seen;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] corner [4];
        corner[0] = '0;
        corner[1] = 16'h0001;
        corner[2] = 16'hFFFF;
        corner[3] = 16'h8000;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        #12;
        check_idle("reset", '0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(16'd3,    16'd5,    0, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 1, 1'b0);
        run_op(16'h1234, 16'h0000, 0, 1'b0);
        run_op(16'h0000, 16'hFFFF, 2, 1'b0);
        run_op(16'hA5A5, 16'h5A5A, 5, 1'b1);

        // Abort an operation halfway through its iterations.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = 16'h00FF;
        bus.in_b     = 16'h0F0F;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("mid_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check_idle("mid_reset", '0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        bus.out_ready = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        bus.out_ready = 1'b0;
        check("no_partial_after_reset", seen, 0);
        run_op(16'd7, 16'd6, 0, 1'b0);

        run_op(16'hFFFE, 16'd3,    0, 1'b0);
        run_op(16'h8000, 16'h8000, 1, 1'b0);
        run_op(16'h8000, 16'h7FFF, 0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            run_op(ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
